mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the multi-cycle core's single unified instruction/data memory port with a second requester (DMA / program loader).
// - One transaction at a time. Fixed memory read latency.
// - Core has priority. A DMA starvation guard forces a DMA grant after MAX_WAIT cycles of waiting.
// - Sits between the multi-cycle datapath's address mux (AdrSrc) and the memory. The core controller stalls on !core_gnt / !core_rvalid.
// PARAMETERS
// AW       32  address width (byte address, word-aligned)
// DW       32  data width
// MEM_LAT  1   memory cycles from mem_en to valid mem_rdata (legal range 1..8)
// MAX_WAIT 8   DMA waiting cycles after which DMA beats core (>=1)
// PORTS
// clk          in   1   rising-edge clock
// rst          in   1   asynchronous, active-low reset
// core_req     in   1   core requests an access
// core_we      in   1   1 = write, 0 = read
// core_addr    in   AW  core address
// core_wdata   in   DW  core write data
// core_gnt     out  1   core request accepted this cycle
// core_rvalid  out  1   1-cycle pulse: core access complete (read data valid / write done)
// core_rdata   out  DW  read data, valid only with core_rvalid
// dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: DMA equivalents of the core_* ports above
// mem_en       out  1   memory access strobe (1 cycle per transaction)
// mem_we       out  1   memory write enable (qualified by mem_en)
// mem_addr     out  AW  memory address
// mem_wdata    out  DW  memory write data
// mem_rdata    in   DW  memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE, lat_cnt=0, wait_cnt=0, owner=NONE.
//   All gnt/rvalid/mem_en/mem_we are 0; rdata/mem_addr/mem_wdata are 0.
// - FSM states: IDLE, BUSY_CORE, BUSY_DMA.
// - IDLE: winner selection is combinational.
//   DMA wins if dma_req && (!core_req || wait_cnt>=MAX_WAIT); else core wins if core_req.
//   Same cycle: winner gnt=1; mem_en=1; mem_we/addr/wdata muxed from the winner.
//   Next state is BUSY_<winner>; lat_cnt loads MEM_LAT-1.
// - BUSY_x: no gnt, mem_en=0. lat_cnt decrements each cycle.
//   In the cycle lat_cnt==0: x_rvalid=1, x_rdata=mem_rdata (pass-through, also for writes); next state is IDLE.
// - Latency: gnt at cycle T, rvalid at T+MEM_LAT. Next grant no earlier than T+MEM_LAT+1.
// - Requester rule: req/we/addr/wdata held stable until gnt. Req may be withdrawn before gnt with no effect.
//   Req at the gnt cycle is consumed; req held high after gnt is a new request.
// - Only the owner gets rvalid. The non-owner's rvalid and rdata stay 0.
// - wait_cnt:
//   - +1 (saturating at MAX_WAIT) each cycle dma_req=1 && !dma_gnt.
//   - Cleared on dma_gnt or when dma_req=0.
//   - Counts during BUSY_* states too.
// - Simultaneous req in IDLE with wait_cnt<MAX_WAIT: core wins.
//   Simultaneous req with wait_cnt==MAX_WAIT: DMA wins; wait_cnt clears.
// - Reset mid-transaction: transaction abandoned. No rvalid is ever issued for it. After release, first grant possible in first IDLE cycle.
// - No address alignment checking; misaligned addresses pass through unchanged.
// STRUCTURE
// - Package mem_arb_pkg holds:
//   - typedef enum logic [1:0] {IDLE, BUSY_CORE, BUSY_DMA} arb_state_t
//   - typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DMA} arb_owner_t
//   - localparam int LAT_W = $clog2(8)+1
// - One sub-module, arb_age_counter: the saturating DMA wait counter with clear.
//   - Params: MAX_WAIT.
//   - Ports: clk, rst, inc, clr, expired.
// - Winner mux, FSM and latency counter stay in mem_port_arbiter.
// TESTING
// 1. Reset then idle, both req=0 for 5 cycles -> all gnt/rvalid/mem_en stay 0.
// 2. MEM_LAT=1: core read at addr 0x10, memory returns 0xDEADBEEF -> core_gnt at T, core_rvalid=1 with rdata 0xDEADBEEF at T+1; dma_rvalid stays 0.
// 3. Both req in IDLE, wait_cnt=0 -> core granted; DMA granted at T+MEM_LAT+1 (MEM_LAT=2: T+3); DMA write to 0x20 reaches mem with mem_we=1.
// 4. Starvation, MAX_WAIT=4, MEM_LAT=1: core req held continuously, DMA req high.
//    -> wait_cnt reaches 4 -> DMA gnt at the next IDLE. Check core is never granted more than 3 consecutive times while DMA waits.
// 5. rst=0 asserted one cycle after core_gnt (MEM_LAT=3) -> outputs 0 immediately (async); no core_rvalid after release; next core req granted in 1st cycle after reset release.
// 6. DMA req withdrawn before gnt after 3 waiting cycles -> wait_cnt=0, no dma_gnt, core unaffected.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the core/DMA memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, BUSY_CORE, BUSY_DMA} arb_state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DMA} arb_owner_t;

   // Wide enough to hold MEM_LAT-1 for the largest legal latency of 8.
   localparam int unsigned LAT_W = $clog2(8) + 1;

   // The core has priority unless the DMA has waited long enough.
   function automatic arb_owner_t pick_winner(input logic core_req,
                                              input logic dma_req,
                                              input logic dma_expired);
      arb_owner_t win;
      win = OWN_NONE;
      if (dma_req && (!core_req || dma_expired)) begin
         win = OWN_DMA;
      end else if (core_req) begin
         win = OWN_CORE;
      end
      return win;
   endfunction

endpackage

// File: rtl/arb_age_counter.sv
// Saturating count of cycles the DMA has been kept waiting; clear wins over increment.
module arb_age_counter #(
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q < CNT_W'(MAX_WAIT))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q >= CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the core's unified memory port with a DMA requester: one transaction
// at a time, fixed read latency, core priority with a DMA starvation guard.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned MEM_LAT  = 1,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          core_req,
   input  logic          core_we,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   output logic          core_gnt,
   output logic          core_rvalid,
   output logic [DW-1:0] core_rdata,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_t       state_q, state_d;
   arb_owner_t       owner_q, owner_d;
   arb_owner_t       win_c;
   logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
   logic             dma_expired;

   arb_age_counter #(
      .MAX_WAIT (MAX_WAIT)
   ) u_age (
      .clk     (clk),
      .rst     (rst),
      .inc     (dma_req && !dma_gnt),
      .clr     (dma_gnt || !dma_req),
      .expired (dma_expired)
   );

   assign win_c = (state_q == IDLE) ? pick_winner(core_req, dma_req, dma_expired) : OWN_NONE;

   // Grant/strobe in the winning IDLE cycle, completion pulse when the latency count hits zero.
   // Everything is gated by rst so an asserted reset silences the port at once.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lat_cnt_d   = lat_cnt_q;
      core_gnt    = 1'b0;
      dma_gnt     = 1'b0;
      core_rvalid = 1'b0;
      dma_rvalid  = 1'b0;
      core_rdata  = '0;
      dma_rdata   = '0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      if (rst) begin
         case (state_q)
            IDLE: begin
               if (win_c == OWN_DMA) begin
                  dma_gnt   = 1'b1;
                  mem_en    = 1'b1;
                  mem_we    = dma_we;
                  mem_addr  = dma_addr;
                  mem_wdata = dma_wdata;
                  state_d   = BUSY_DMA;
               end else if (win_c == OWN_CORE) begin
                  core_gnt  = 1'b1;
                  mem_en    = 1'b1;
                  mem_we    = core_we;
                  mem_addr  = core_addr;
                  mem_wdata = core_wdata;
                  state_d   = BUSY_CORE;
               end
               if (win_c != OWN_NONE) begin
                  owner_d   = win_c;
                  lat_cnt_d = LAT_W'(MEM_LAT - 1);
               end
            end
            BUSY_CORE, BUSY_DMA: begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
               if (lat_cnt_q == '0) begin
                  if (owner_q == OWN_CORE) begin
                     core_rvalid = 1'b1;
                     core_rdata  = mem_rdata;
                  end else if (owner_q == OWN_DMA) begin
                     dma_rvalid = 1'b1;
                     dma_rdata  = mem_rdata;
                  end
                  state_d   = IDLE;
                  owner_d   = OWN_NONE;
                  lat_cnt_d = '0;
               end
            end
            default: begin
               state_d = IDLE;
               owner_d = OWN_NONE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         owner_q   <= OWN_NONE;
         lat_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         lat_cnt_q <= lat_cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a cycle-count reference model of the arbitration rules.
module tb_mem_port_arbiter;

   parameter int unsigned MEM_LAT  = 2;
   parameter int unsigned MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_we, dma_req, dma_we;
   logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata;
   logic        core_gnt, core_rvalid, dma_gnt, dma_rvalid;
   logic [31:0] core_rdata, dma_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   mem_port_arbiter #(
      .AW       (32),
      .DW       (32),
      .MEM_LAT  (MEM_LAT),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .core_req    (core_req),
      .core_we     (core_we),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .core_gnt    (core_gnt),
      .core_rvalid (core_rvalid),
      .core_rdata  (core_rdata),
      .dma_req     (dma_req),
      .dma_we      (dma_we),
      .dma_addr    (dma_addr),
      .dma_wdata   (dma_wdata),
      .dma_gnt     (dma_gnt),
      .dma_rvalid  (dma_rvalid),
      .dma_rdata   (dma_rdata),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory behind the port: writes land at the strobe, reads come back MEM_LAT cycles later.
   typedef struct {
      int          due;
      logic [31:0] addr;
   } pend_t;

   logic [31:0] mem [logic [31:0]];
   pend_t       pend[$];

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return ~a;
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         pend.delete();
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] = mem_wdata;
         pend.push_back('{cyc + int'(MEM_LAT), mem_addr});
      end
      cyc++;
      #1;
      if (pend.size() != 0 && pend[0].due == cyc) begin
         mem_rdata = rd(pend[0].addr);
         void'(pend.pop_front());
      end else begin
         mem_rdata = $urandom;
      end
   end

   // Reference model: the port is free from cycle m_free_at on, the owner's completion
   // falls on cycle m_done_at, and m_waited counts cycles the DMA has sat ungranted.
   int m_free_at = 0;
   int m_done_at = -1;
   int m_owner   = 0;
   int m_waited  = 0;

   always @(negedge clk) begin : model
      int          win;
      logic        e_cg, e_dg, e_cv, e_dv, e_we;
      logic [31:0] e_ad, e_wd;
      if (!rst) begin
         chk("rst_core_gnt", core_gnt, 0);
         chk("rst_dma_gnt", dma_gnt, 0);
         chk("rst_core_rvalid", core_rvalid, 0);
         chk("rst_dma_rvalid", dma_rvalid, 0);
         chk("rst_mem_en", mem_en, 0);
         chk("rst_mem_we", mem_we, 0);
         chk("rst_mem_addr", mem_addr, 0);
         chk("rst_mem_wdata", mem_wdata, 0);
         chk("rst_core_rdata", core_rdata, 0);
         chk("rst_dma_rdata", dma_rdata, 0);
         m_free_at = cyc;
         m_done_at = -1;
         m_owner   = 0;
         m_waited  = 0;
      end else begin
         win = 0;
         if (cyc >= m_free_at) begin
            if (dma_req && (!core_req || m_waited >= int'(MAX_WAIT))) win = 2;
            else if (core_req) win = 1;
         end
         e_cg = (win == 1);
         e_dg = (win == 2);
         e_cv = (cyc == m_done_at) && (m_owner == 1);
         e_dv = (cyc == m_done_at) && (m_owner == 2);
         e_we = (win == 2) ? dma_we : core_we;
         e_ad = (win == 2) ? dma_addr : core_addr;
         e_wd = (win == 2) ? dma_wdata : core_wdata;
         chk("core_gnt", core_gnt, e_cg);
         chk("dma_gnt", dma_gnt, e_dg);
         chk("mem_en", mem_en, e_cg || e_dg);
         if (win != 0) begin
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_ad);
            chk("mem_wdata", mem_wdata, e_wd);
         end
         chk("core_rvalid", core_rvalid, e_cv);
         chk("dma_rvalid", dma_rvalid, e_dv);
         chk("core_rdata", core_rdata, e_cv ? mem_rdata : 32'h0);
         chk("dma_rdata", dma_rdata, e_dv ? mem_rdata : 32'h0);
         if (win != 0) begin
            m_owner   = win;
            m_done_at = cyc + int'(MEM_LAT);
            m_free_at = m_done_at + 1;
         end
         if (!dma_req || win == 2) m_waited = 0;
         else if (m_waited < int'(MAX_WAIT)) m_waited++;
      end
   end

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int   consec;
      logic got, cg, dg;
      rst = 1'b0;
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
      dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = '0; dma_wdata  = '0;
      mem_rdata = '0;
      mem[32'h10] = 32'hDEAD_BEEF;
      #3;
      chk("init_core_gnt", core_gnt, 0);
      chk("init_mem_en", mem_en, 0);
      chk("init_mem_addr", mem_addr, 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;

      // Idle with no requests.
      repeat (5) begin
         @(negedge clk);
         chk("idle_mem_en", mem_en, 0);
         chk("idle_core_gnt", core_gnt, 0);
         chk("idle_dma_gnt", dma_gnt, 0);
         next();
      end

      // Core read of 0x10.
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10; core_wdata = $urandom;
      @(negedge clk);
      chk("t2_core_gnt", core_gnt, 1);
      chk("t2_mem_addr", mem_addr, 32'h10);
      next();
      core_req = 1'b0;
      for (int k = 1; k <= int'(MEM_LAT); k++) begin
         if (k > 1) next();
         @(negedge clk);
         chk("t2_dma_rvalid", dma_rvalid, 0);
         if (k < int'(MEM_LAT)) begin
            chk("t2_early_rvalid", core_rvalid, 0);
         end else begin
            chk("t2_core_rvalid", core_rvalid, 1);
            chk("t2_core_rdata", core_rdata, 32'hDEAD_BEEF);
         end
      end
      next();

      // Simultaneous requests with a fresh DMA: core first, DMA write right after.
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h30;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h1234_5678;
      @(negedge clk);
      chk("t3_core_gnt", core_gnt, 1);
      chk("t3_dma_held", dma_gnt, 0);
      next();
      core_req = 1'b0;
      repeat (MEM_LAT) begin
         @(negedge clk);
         chk("t3_dma_wait", dma_gnt, 0);
         next();
      end
      @(negedge clk);
      chk("t3_dma_gnt", dma_gnt, 1);
      chk("t3_mem_we", mem_we, 1);
      chk("t3_mem_addr", mem_addr, 32'h20);
      chk("t3_mem_wdata", mem_wdata, 32'h1234_5678);
      next();
      dma_req = 1'b0;
      repeat (MEM_LAT) next();
      chk("t3_mem_written", rd(32'h20), 32'h1234_5678);

      // Starvation guard: core requests back to back while the DMA waits.
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h44;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40;
      consec = 0;
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         if (dma_gnt) got = 1'b1;
         else if (core_gnt) consec++;
         next();
      end
      core_req = 1'b0;
      dma_req = 1'b0;
      chk("t4_dma_granted", got, 1);
      chk("t4_core_streak_bound", consec <= int'(MAX_WAIT) - 1, 1);
      chk("t4_core_grants", consec, (MAX_WAIT + MEM_LAT) / (MEM_LAT + 1));
      repeat (MEM_LAT) next();

      // Reset one cycle after a core grant abandons the transaction.
      core_req = 1'b1; core_we = 1'b0; core_addr = 32'h10;
      @(negedge clk);
      chk("t5_core_gnt", core_gnt, 1);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("t5_async_rvalid", core_rvalid, 0);
      chk("t5_async_mem_en", mem_en, 0);
      chk("t5_async_gnt", core_gnt, 0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk("t5_first_gnt", core_gnt, 1);
      next();
      core_req = 1'b0;
      repeat (MEM_LAT) next();

      // DMA withdraws after waiting behind one core transaction.
      core_req = 1'b1; core_addr = 32'h50;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h60;
      @(negedge clk);
      chk("t6_core_first", core_gnt, 1);
      next();
      core_req = 1'b0;
      repeat (MEM_LAT) begin
         @(negedge clk);
         chk("t6_dma_waiting", dma_gnt, 0);
         next();
      end
      dma_req = 1'b0;
      core_req = 1'b1; core_addr = 32'h54;
      @(negedge clk);
      chk("t6_withdrawn", dma_gnt, 0);
      chk("t6_core_again", core_gnt, 1);
      next();
      core_req = 1'b0;
      repeat (MEM_LAT) next();
      core_req = 1'b1; dma_req = 1'b1;
      @(negedge clk);
      chk("t6_core_wins_fresh", core_gnt, 1);
      repeat (2 * MAX_WAIT + 2 * MEM_LAT) begin
         next();
         @(negedge clk);
      end
      next();
      core_req = 1'b0;
      dma_req = 1'b0;
      repeat (MEM_LAT + 1) next();

      // Randomized traffic with withdrawals and occasional resets.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         cg = core_gnt;
         dg = dma_gnt;
         next();
         rst = ($urandom_range(299) != 0);
         if (!core_req || cg) begin
            core_req   = ($urandom_range(99) < 45);
            core_we    = 1'($urandom);
            core_addr  = 32'($urandom_range(255));
            core_wdata = $urandom;
         end
         if (!dma_req || dg) begin
            dma_req   = ($urandom_range(99) < 40);
            dma_we    = 1'($urandom);
            dma_addr  = 32'($urandom_range(255));
            dma_wdata = $urandom;
         end else if ($urandom_range(99) < 4) begin
            dma_req = 1'b0;
         end
      end
      next();
      rst = 1'b1;
      core_req = 1'b0;
      dma_req = 1'b0;
      repeat (MEM_LAT + 2) next();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
